// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin arbiter/sequencer sharing one 8-bit ALU between
// N requesters. Accepts a request in IDLE, runs the ALU start/done exchange,
// and returns the captured result to the winner with a one-cycle strobe.
// Optional build macro: ALU_ARB_TIMEOUT_EN adds an ALU watchdog that resets
// the ALU for one cycle and answers with an error after TIMEOUT cycles.
//
// Handshake: a requester holds req high; gnt[i] pulses combinationally in the
// IDLE cycle that accepts it, and operands are sampled only in that cycle.
// rsp_valid[i] pulses once per accepted request (rsp_err/rsp_result qualify
// it). The ALU sees alu_start held high until alu_done is sampled high.
module alu_rr_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*8-1:0] req_a,
  input  logic [N*8-1:0] req_b,
  input  logic [N*3-1:0] req_op,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   rsp_valid,
  output logic           rsp_err,
  output logic [15:0]    rsp_result,
  output logic           alu_start,
  output logic [7:0]     alu_a,
  output logic [7:0]     alu_b,
  output logic [2:0]     alu_op,
  input  logic           alu_done,
  input  logic [15:0]    alu_result,
  output logic           alu_rst_n,
  output logic [1:0]     dbg_state
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  // S_RECOVER is only reachable when the watchdog is built in.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RESP    = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win_q;
  logic [PW-1:0] win_idx;
  logic          win_vld;
  logic [PW:0]   cand;
  logic [N-1:0]  mask_q;
  logic [N-1:0]  eff_req;
  logic [7:0]    sel_a;
  logic [7:0]    sel_b;
  logic [2:0]    sel_op;
  logic          sel_legal;
  logic          tmo_hit;

  // The previous winner sits out exactly one IDLE cycle after its response.
  assign eff_req   = req & ~mask_q;
  assign sel_legal = (sel_op != 3'd0) && (sel_op <= 3'd4);
  assign dbg_state = state_q;

  // Round-robin search: first requester after the pointer, wrapping at N.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
      if (!win_vld && eff_req[cand[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
  end

  // Operand mux for the current winner.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == PW'(i)) begin
        sel_a  = req_a[8*i +: 8];
        sel_b  = req_b[8*i +: 8];
        sel_op = req_op[3*i +: 3];
      end
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  logic [CW-1:0] cnt_q;
  logic          rec_q;

  // Last ISSUE cycle allowed before the watchdog fires.
  assign tmo_hit   = (cnt_q == CW'(TIMEOUT-1));
  assign alu_rst_n = rst_n & ~rec_q;

  // Watchdog: counts ISSUE cycles, cleared whenever not issuing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rec_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == S_ISSUE) ? cnt_q + CW'(1) : '0;
      rec_q <= (state_d == S_RECOVER);
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign alu_rst_n = rst_n;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (win_vld) state_d = sel_legal ? S_ISSUE : S_RESP;
      S_ISSUE: begin
        if (alu_done)     state_d = S_RESP;
        else if (tmo_hit) state_d = S_RECOVER;
      end
      S_RECOVER: state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Decoded outputs; gnt is gated by rst_n so nothing is granted in reset.
  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    alu_start = (state_q == S_ISSUE);
    if (state_q == S_IDLE && win_vld && rst_n) gnt[win_idx] = 1'b1;
    if (state_q == S_RESP) rsp_valid[win_q] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: operand latch, pointer/mask update and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= PW'(N-1);
      win_q      <= '0;
      mask_q     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_err    <= 1'b0;
      rsp_result <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          mask_q <= '0;
          if (win_vld) begin
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            alu_op <= sel_op;
            ptr_q  <= win_idx;
            win_q  <= win_idx;
            if (!sel_legal) begin
              rsp_err    <= 1'b1;
              rsp_result <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (alu_done) begin
            rsp_err    <= 1'b0;
            rsp_result <= alu_result;
          end else if (tmo_hit) begin
            rsp_err    <= 1'b1;
            rsp_result <= 16'hFFFF;
          end
        end
        S_RESP:  mask_q <= N'(1) << win_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed and random stimulus for alu_rr_arbiter against
// a transaction-level model (round-robin pick, protocol phases, ALU function).
module tb_alu_rr_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int P_FREE = 0, P_WORK = 1, P_RECOV = 2, P_RESP = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req;
  logic [N*8-1:0] req_a, req_b;
  logic [N*3-1:0] req_op;
  logic [N-1:0]   gnt, rsp_valid;
  logic           rsp_err, alu_start, alu_done, alu_rst_n;
  logic [15:0]    rsp_result, alu_result;
  logic [7:0]     alu_a, alu_b;
  logic [2:0]     alu_op;
  logic [1:0]     dbg_state;

  logic [7:0] a_arr [N];
  logic [7:0] b_arr [N];
  logic [2:0] op_arr[N];

  always_comb begin
    req_a  = '0;
    req_b  = '0;
    req_op = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*8 +: 8]  = a_arr[i];
      req_b[i*8 +: 8]  = b_arr[i];
      req_op[i*3 +: 3] = op_arr[i];
    end
  end

  alu_rr_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_result(rsp_result), .alu_start(alu_start), .alu_a(alu_a),
    .alu_b(alu_b), .alu_op(alu_op), .alu_done(alu_done),
    .alu_result(alu_result), .alu_rst_n(alu_rst_n), .dbg_state(dbg_state)
  );

  // ---------------- reference ALU function ----------------
  function automatic logic [15:0] alu_ref(input logic [2:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
    case (op)
      3'd1:    return {8'h00, a} + {8'h00, b};
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return a * b;
      default: return 16'h0000;
    endcase
  endfunction

  // ---------------- behavioural ALU ----------------
  int   lat = 1;
  logic never_done = 1'b0;
  logic spur_done  = 1'b0;
  int   acnt;

  always @(posedge clk or negedge alu_rst_n) begin
    if (!alu_rst_n) acnt <= 0;
    else if (alu_start && !alu_done) acnt <= acnt + 1;
    else acnt <= 0;
  end
  assign alu_done   = (alu_start && !never_done && acnt == lat - 1) || spur_done;
  assign alu_result = alu_ref(alu_op, alu_a, alu_b);

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / transaction model ----------------
  logic [19:0] exp_q[$];   // {err, idx[2:0], result}
  int gnt_hist[$];
  int ph = P_FREE, last = N - 1, cur = 0, mask_idx = -1, tmo = 0;
  logic mon_en = 1'b1;

  function automatic int pick(input logic [N-1:0] r, input int lst);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (lst + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      ph = P_FREE; last = N - 1; mask_idx = -1; tmo = 0;
      exp_q.delete();
    end else if (mon_en) begin
      logic [N-1:0] eff, exp_gnt, exp_rsp;
      logic [19:0]  e;
      int nph, w;
      exp_gnt = '0;
      exp_rsp = '0;
      nph = ph;
      case (ph)
        P_FREE: begin
          eff = req;
          if (mask_idx >= 0) eff[mask_idx] = 1'b0;
          mask_idx = -1;
          w = pick(eff, last);
          if (w >= 0) begin
            exp_gnt[w] = 1'b1;
            last = w; cur = w; tmo = 0;
            if (op_arr[w] >= 3'd1 && op_arr[w] <= 3'd4) begin
              exp_q.push_back({1'b0, 3'(w), alu_ref(op_arr[w], a_arr[w], b_arr[w])});
              nph = P_WORK;
            end else begin
              exp_q.push_back({1'b1, 3'(w), 16'h0000});
              nph = P_RESP;
            end
          end
        end
        P_WORK: begin
          tmo++;
          if (alu_done) nph = P_RESP;
`ifdef ALU_ARB_TIMEOUT_EN
          else if (tmo == TO) begin
            void'(exp_q.pop_back());
            exp_q.push_back({1'b1, 3'(cur), 16'hFFFF});
            nph = P_RECOV;
          end
`endif
        end
        P_RECOV: nph = P_RESP;
        default: begin
          exp_rsp[cur] = 1'b1;
          mask_idx = cur;
          nph = P_FREE;
        end
      endcase
      for (int i = 0; i < N; i++) if (gnt[i]) gnt_hist.push_back(i);
      check_eq("gnt", gnt, exp_gnt);
      check_eq("alu_start", alu_start, ph == P_WORK);
      check_eq("alu_rst_n", alu_rst_n, ph != P_RECOV);
      check_eq("rsp_valid", rsp_valid, exp_rsp);
      if (ph == P_RESP) begin
        if (exp_q.size() == 0) check_eq("exp_q_empty", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("rsp_err", rsp_err, e[19]);
          check_eq("rsp_result", rsp_result, e[15:0]);
        end
      end
      ph = nph;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic wait_free(input int max_cyc);
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      #1;
      if (ph == P_FREE && exp_q.size() == 0) return;
    end
    check_eq("wait_free_timeout", 0, 1);
  endtask

  task automatic set_all(input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b);
    for (int i = 0; i < N; i++) begin
      op_arr[i] = op; a_arr[i] = a; b_arr[i] = b;
    end
  endtask

  task automatic single_err(input logic [2:0] op);
    next_cycle;
    op_arr[2] = op;
    req = 4'b0100;
    @(negedge clk);
    check_eq("err_gnt", gnt, 4'b0100);
    check_eq("err_start0", alu_start, 0);
    next_cycle;
    req = '0;
    @(negedge clk);
    check_eq("err_rsp", rsp_valid, 4'b0100);
    check_eq("err_flag", rsp_err, 1);
    check_eq("err_result", rsp_result, 0);
    check_eq("err_start1", alu_start, 0);
    wait_free(10);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    req = '0;
    set_all(3'd0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_start", alu_start, 0);
    check_eq("rst_alu_rst_n", alu_rst_n, 0);
    check_eq("rst_result", rsp_result, 0);
    check_eq("rst_ops", {alu_a, alu_b, 5'd0, alu_op}, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // add FF+FF, ALU latency 3
    next_cycle;
    lat = 3;
    a_arr[0] = 8'hFF; b_arr[0] = 8'hFF; op_arr[0] = 3'd1;
    req = 4'b0001;
    @(negedge clk);
    check_eq("t1_gnt", gnt, 4'b0001);
    next_cycle;
    req = '0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check_eq("t1_start", alu_start, 1);
      next_cycle;
    end
    @(negedge clk);
    check_eq("t1_rsp", rsp_valid, 4'b0001);
    check_eq("t1_result", rsp_result, 16'h01FE);
    check_eq("t1_err", rsp_err, 0);
    wait_free(10);

    // all four requesting mul, fresh pointer
    do_reset();
    next_cycle;
    lat = 2;
    set_all(3'd4, 8'h10, 8'h10);
    gnt_hist.delete();
    req = 4'b1111;
    for (int c = 0; c < 60 && gnt_hist.size() < 5; c++) next_cycle;
    req = '0;
    wait_free(20);
    check_eq("rr_count", gnt_hist.size() >= 5, 1);
    for (int i = 0; i < 5 && i < gnt_hist.size(); i++)
      check_eq("rr_order", gnt_hist[i], i % N);
    for (int i = 0; i + N <= gnt_hist.size(); i++) begin
      int dup;
      dup = 0;
      for (int j = i; j < i + N; j++)
        for (int k = j + 1; k < i + N; k++)
          if (gnt_hist[j] == gnt_hist[k]) dup++;
      check_eq("rr_window", dup, 0);
    end

    // no_op and illegal op
    single_err(3'd0);
    single_err(3'd7);

    // xor with operand change after grant
    next_cycle;
    a_arr[1] = 8'hA5; b_arr[1] = 8'h0F; op_arr[1] = 3'd3;
    req = 4'b0010;
    @(negedge clk);
    check_eq("t4_gnt", gnt, 4'b0010);
    next_cycle;
    req = '0;
    a_arr[1] = 8'h00;
    @(negedge clk);
    check_eq("t4_alu_a", alu_a, 8'hA5);
    for (int c = 0; c < 10 && rsp_valid == '0; c++) @(negedge clk);
    check_eq("t4_rsp", rsp_valid, 4'b0010);
    check_eq("t4_result", rsp_result, 16'h00AA);
    wait_free(10);

    // async reset while issuing
    next_cycle;
    never_done = 1'b1;
    op_arr[3] = 3'd1;
    req = 4'b1000;
    repeat (3) next_cycle;
    req = '0;
    check_eq("t5_in_issue", alu_start, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_start", alu_start, 0);
    check_eq("t5_alu_rst_n", alu_rst_n, 0);
    check_eq("t5_rsp", rsp_valid, 0);
    check_eq("t5_gnt", gnt, 0);
    check_eq("t5_result", rsp_result, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    never_done = 1'b0;
    next_cycle;
    set_all(3'd1, 8'h01, 8'h02);
    req = 4'b1111;
    @(negedge clk);
    check_eq("t5_first", gnt, 4'b0001);
    next_cycle;
    req = '0;
    wait_free(20);

    // ALU never answers
    next_cycle;
    never_done = 1'b1;
    op_arr[2] = 3'd2;
    req = 4'b0100;
    next_cycle;
    req = '0;
`ifdef ALU_ARB_TIMEOUT_EN
    begin
      int n_hi, n_rl;
      n_hi = 0; n_rl = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (alu_start) n_hi++;
        if (!alu_rst_n) n_rl++;
        if (rsp_valid != '0) begin
          check_eq("t6_err", rsp_err, 1);
          check_eq("t6_result", rsp_result, 16'hFFFF);
          break;
        end
      end
      check_eq("t6_start_cycles", n_hi, TO);
      check_eq("t6_rst_cycles", n_rl, 1);
    end
    never_done = 1'b0;
    wait_free(10);
`else
    repeat (20) @(negedge clk);
    check_eq("t6_still_issue", alu_start, 1);
    check_eq("t6_no_rsp", rsp_valid, 0);
    never_done = 1'b0;
    do_reset();
`endif

    // random traffic
    for (int c = 0; c < 400; c++) begin
      next_cycle;
      if ($urandom_range(0, 2) == 0) req = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        a_arr[i]  = 8'($urandom);
        b_arr[i]  = 8'($urandom);
        op_arr[i] = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(1, 4))
                                                : 3'($urandom_range(0, 7));
      end
      if (!alu_start) lat = $urandom_range(1, 4);
      spur_done = ($urandom_range(0, 7) == 0);
    end
    next_cycle;
    req = '0;
    spur_done = 1'b0;
    wait_free(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit ALU (start/done handshake, operands A/B, 3-bit op, 16-bit result) between N requesters.
- Latches the winning request, drives the ALU start protocol, captures the result and returns it to the winner with a one-cycle response strobe.
- Sits between client blocks and the ALU, and is the only driver of the ALU inputs.

Parameters:
N, 4, number of requesters (2..8).
TIMEOUT, 64, max cycles the ALU start may stay high without done; used only with ALU_ARB_TIMEOUT_EN.

Ports:
clk  in  1  system clock, all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
req  in  N  per-requester request level.
req_a  in  N*8  operand A, requester i at [8i+7:8i].
req_b  in  N*8  operand B, same packing.
req_op  in  N*3  op code, requester i at [3i+2:3i].
gnt  out  N  one-hot, 1-cycle pulse when a request is accepted.
rsp_valid  out  N  one-hot, 1-cycle pulse when the response for requester i is ready.
rsp_err  out  1  qualifies rsp_valid: illegal op or timeout.
rsp_result  out  16  result, valid with rsp_valid.
alu_start  out  1  ALU start.
alu_a  out  8  ALU operand A.
alu_b  out  8  ALU operand B.
alu_op  out  3  ALU op select.
alu_done  in  1  ALU done.
alu_result  in  16  ALU result.
alu_rst_n  out  1  ALU reset, = rst_n AND internal recovery reset.

Behaviour:
- Op encoding: 000 no_op, 001 add, 010 and, 011 xor, 100 mul. Codes 101..111 are illegal.
- Reset (async): state IDLE. gnt, rsp_valid, rsp_err, alu_start = 0. rsp_result, alu_a, alu_b, alu_op = 0. Round-robin pointer = N-1, so requester 0 has first priority. Internal recovery reset inactive.
- IDLE: if any unmasked req is high:
  - Pick the winner as the first set bit searching from pointer+1 with wrap-around.
  - Pulse gnt[w]. Latch req_a/req_b/req_op into alu_a/alu_b/alu_op. Set pointer = w.
  - Legal non-no_op: go to ISSUE.
  - no_op or illegal: go to RESP with rsp_err = 1 and result 0. The ALU is not started.
- ISSUE: alu_start = 1 from the first ISSUE cycle. alu_a/b/op stay held.
  - When alu_done is sampled high: capture alu_result and go to RESP.
- RESP:
  - Outputs for this one cycle: alu_start = 0; rsp_valid[w] = 1; rsp_result = captured value; rsp_err as set.
  - Go to IDLE.
  - req[w] is masked for the next IDLE cycle only. A req still high after that is a new request.
- Latency, legal op: req sampled in cycle 0 → gnt in cycle 0 → alu_start high from cycle 1 → done sampled in cycle k → rsp_valid in cycle k+1 → next grant possible no earlier than cycle k+2.
- Requesters must hold operands stable only in the cycle gnt is high. Later changes have no effect.
- A req dropped before its grant is simply lost; no response is given.
- Simultaneous requests: strict round-robin. Each requester waits at most N-1 grants.
- alu_done high while not in ISSUE is ignored.
- Async reset mid-operation: immediate return to IDLE. No response is issued for the in-flight request. alu_rst_n follows rst_n.

Optional Feature:
ALU_ARB_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to ISSUE and increments each ISSUE cycle.
  - If it reaches TIMEOUT without alu_done: drop alu_start, drive alu_rst_n low for exactly 1 cycle, then go to RESP with rsp_err = 1 and rsp_result = 16'hFFFF.
  - Counter width is $clog2(TIMEOUT+1).
- Undefined: no counter. ISSUE waits for done indefinitely, and alu_rst_n = rst_n.

Test Plan:
- Reset then req=0001, A=8'hFF, B=8'hFF, op=add; ALU model returns done after 3 cycles → gnt[0] in cycle 0, alu_start high cycles 1..3, rsp_valid[0] in cycle 4, rsp_result=16'h01FE, rsp_err=0.
- req=1111 held continuously, all op=mul, A=B=8'h10 → grant order 0,1,2,3,0; each response 16'h0100; no requester granted twice within any 4 consecutive grants.
- req[2] with op=no_op → gnt[2] then rsp_valid[2] on the next cycle, rsp_err=1, result 0, alu_start never asserted. Repeat the same check with op=3'b111.
- req[1] with op=xor, A=8'hA5, B=8'h0F; change req_a to 8'h00 the cycle after gnt → alu_a stays 8'hA5, result 16'h00AA.
- rst_n low for 1 cycle while in ISSUE → all outputs 0 immediately, alu_rst_n low, no rsp_valid; after release, req[0] is granted first.
- With ALU_ARB_TIMEOUT_EN and TIMEOUT=8, the ALU model never asserts done → alu_start drops after 8 cycles, alu_rst_n low for 1 cycle, rsp_err=1, rsp_result=16'hFFFF. Without the macro, the arbiter stays in ISSUE.
